// File: rtl/z8_pkg.sv
// Shared core definitions: data word width, register-file address type and
// writeback requester indices.
package z8_pkg;

    localparam int unsigned WORD_SIZE = 16;

    typedef logic [1:0] rf_addr_t;

    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LOAD = 1;
    localparam int unsigned REQ_DBG  = 2;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between the requesters and the register-file write arbiter.
// The master side is the requester group; the slave side is the arbiter.
interface rf_write_arbiter_if
    import z8_pkg::*;
#(
    parameter int unsigned N_REQ = 3
) ();

    logic [N_REQ-1:0]                req_valid;
    rf_addr_t [N_REQ-1:0]            req_addr;
    logic [N_REQ-1:0][WORD_SIZE-1:0] req_data;
    logic [N_REQ-1:0]                req_ready;
    logic                            lock;

    logic                            rf_write_enable;
    rf_addr_t                        rf_write_addr;
    logic [WORD_SIZE-1:0]            rf_write_data;
    logic [1:0]                      grant_idx;

    modport master (
        output req_valid, req_addr, req_data, lock,
        input  req_ready, rf_write_enable, rf_write_addr, rf_write_data, grant_idx
    );

    modport slave (
        input  req_valid, req_addr, req_data, lock,
        output req_ready, rf_write_enable, rf_write_addr, rf_write_data, grant_idx
    );

endinterface

// File: rtl/rr_arbiter.sv
// Stateless rotate-priority selector: starting at ptr, grant the first
// requester that is both requesting and eligible. The pointer lives in the
// parent so this block can be shared by other arbitration points.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic [1:0]   ptr,
    output logic [N-1:0] grant,
    output logic [1:0]   idx,
    output logic         any
);

    logic [2:0] slot;
    logic [1:0] cand;

    // Walk ptr, ptr+1, ... mod N and latch the first eligible requester.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        slot  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            slot = {1'b0, ptr} + 3'(k);
            if (slot >= 3'(N)) begin
                slot = slot - 3'(N);
            end
            cand = slot[1:0];
            if (!any && req[cand] && mask[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port. The grant is
// combinational; the accepted write is registered onto rf_write_* one cycle
// later, where it also serves as the forwarding source for the read stage.
module rf_write_arbiter
    import z8_pkg::*;
#(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned LOCK_REQ = REQ_DBG
) (
    input  logic               clk,
    input  logic               reset,
    rf_write_arbiter_if.slave  bus
);

    logic [N_REQ-1:0]     eligible;
    logic [N_REQ-1:0]     grant;
    logic [1:0]           grant_sel;
    logic                 grant_any;

    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic                 wr_en_q;
    rf_addr_t             wr_addr_q;
    logic [WORD_SIZE-1:0] wr_data_q;
    logic [1:0]           wr_idx_q;

    // Eligibility: nobody during reset, only the lock owner while locked.
    always_comb begin
        eligible = '0;
        if (reset) begin
            if (bus.lock) begin
                eligible[LOCK_REQ] = 1'b1;
            end else begin
                eligible = '1;
            end
        end
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req   (bus.req_valid),
        .mask  (eligible),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_sel),
        .any   (grant_any)
    );

    assign bus.req_ready = grant;

    // Advance the pointer past the winner; locked grants leave it untouched so
    // round-robin resumes where it left off once the lock drops.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any && !bus.lock) begin
            rr_ptr_d = (grant_sel == 2'(N_REQ - 1)) ? 2'd0 : grant_sel + 2'd1;
        end
    end

    // Pointer and write-stage registers; reset drops any write accepted just before it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_idx_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_en_q  <= grant_any;
            if (grant_any) begin
                wr_addr_q <= bus.req_addr[grant_sel];
                wr_data_q <= bus.req_data[grant_sel];
                wr_idx_q  <= grant_sel;
            end
        end
    end

    assign bus.rf_write_enable = wr_en_q;
    assign bus.rf_write_addr   = wr_addr_q;
    assign bus.rf_write_data   = wr_data_q;
    assign bus.grant_idx       = wr_idx_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a driver applies directed and random requests,
// predicts each grant from the round-robin rules and queues the expected
// write; an independent monitor pops and checks each write as it appears.
module tb_rf_write_arbiter;
    import z8_pkg::*;

    typedef struct {
        rf_addr_t    addr;
        logic [15:0] data;
        logic [1:0]  idx;
    } exp_t;

    logic clk;
    logic reset;

    rf_write_arbiter_if #(.N_REQ(3)) bus ();

    rf_write_arbiter #(
        .N_REQ    (3),
        .LOCK_REQ (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    exp_t        q[$];
    logic [15:0] rf_mem [4] = '{default: 16'h0};
    logic [15:0] model_mem [4] = '{default: 16'h0};
    int          ptr = 0;
    rf_addr_t    last_a = '0;
    logic [15:0] last_d = '0;

    logic [2:0]  v;
    rf_addr_t    a [3];
    logic [15:0] d [3];
    logic        lk;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file fed by the arbiter output stage.
    always @(posedge clk) begin
        if (bus.rf_write_enable) rf_mem[bus.rf_write_addr] <= bus.rf_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Grant prediction: first valid, eligible requester in circular order from ptr.
    function automatic int pick(input logic [2:0] vv, input logic l, input int p,
                                input logic r);
        if (!r) return -1;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (p + k) % 3;
            if (vv[i] && (!l || i == 2)) return i;
        end
        return -1;
    endfunction

    task automatic drive();
        bus.req_valid = v;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr[i] = a[i];
            bus.req_data[i] = d[i];
        end
        bus.lock = lk;
    endtask

    task automatic new_req(input int i);
        v[i] = 1'b1;
        a[i] = rf_addr_t'($urandom_range(0, 3));
        d[i] = 16'($urandom);
    endtask

    // One clock cycle: check the grant, then account for the write it implies.
    task automatic cycle(input bit drop, output int g);
        @(negedge clk);
        g = pick(v, lk, ptr, reset);
        chk("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        if (drop) begin
            #3;
            reset = 1'b0;
        end
        if (reset) begin
            if (g >= 0) begin
                q.push_back('{addr: a[g], data: d[g], idx: 2'(g)});
                model_mem[a[g]] = d[g];
                last_a = a[g];
                last_d = d[g];
                if (!lk) ptr = (g + 1) % 3;
            end
        end else begin
            ptr = 0;
            last_a = '0;
            last_d = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        int g;
        reset = 1'b0;
        drive();
        cycle(1'b0, g);
        reset = 1'b1;
    endtask

    // Monitor: every presented write must match the oldest predicted one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rf_write_enable === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got enable 1 expected no write at %0t",
                             $time);
                end else begin
                    e = q.pop_front();
                    chk("rf_write_addr", 32'(bus.rf_write_addr), 32'(e.addr));
                    chk("rf_write_data", 32'(bus.rf_write_data), 32'(e.data));
                    chk("grant_idx", 32'(bus.grant_idx), 32'(e.idx));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int d_prior;
        reset = 1'b0;
        v = 3'b111;
        lk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a[i] = rf_addr_t'(i);
            d[i] = 16'h1000 + 16'(i);
        end
        drive();
        repeat (2) cycle(1'b0, g);
        chk("reset_enable", 32'(bus.rf_write_enable), 32'd0);
        chk("reset_addr", 32'(bus.rf_write_addr), 32'd0);
        chk("reset_data", 32'(bus.rf_write_data), 32'd0);
        chk("reset_idx", 32'(bus.grant_idx), 32'd0);
        reset = 1'b1;

        // Single request from the ALU.
        v = 3'b001;
        a[0] = 2'd2;
        d[0] = 16'hBEEF;
        drive();
        cycle(1'b0, g);
        v = 3'b000;
        drive();
        cycle(1'b0, g);
        cycle(1'b0, g);
        chk("rf_mem2_beef", 32'(rf_mem[2]), 32'h0000BEEF);

        // All three valid from reset: strict rotation, a write every cycle.
        v = 3'b111;
        reset_pulse();
        for (int k = 0; k < 6; k++) begin
            drive();
            cycle(1'b0, g);
            if (g >= 0) new_req(g);
        end
        v = 3'b000;
        drive();
        cycle(1'b0, g);

        // Two same-cycle writes to register 3 are serialized, requester 1 last.
        reset_pulse();
        v = 3'b011;
        a[0] = 2'd3;
        d[0] = 16'h1111;
        a[1] = 2'd3;
        d[1] = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            drive();
            cycle(1'b0, g);
            if (g >= 0) v[g] = 1'b0;
        end
        chk("rf_mem3_final", 32'(rf_mem[3]), 32'h00002222);

        // Lock: only requester 2 wins and the pointer is frozen; then resume.
        v = 3'b111;
        for (int i = 0; i < 3; i++) new_req(i);
        lk = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive();
            cycle(1'b0, g);
            if (g >= 0) new_req(g);
        end
        lk = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive();
            cycle(1'b0, g);
            if (g >= 0) new_req(g);
        end

        // Write accepted right before reset is dropped.
        v = 3'b001;
        a[0] = 2'd1;
        d[0] = 16'h5A5A;
        d_prior = int'(model_mem[1]);
        drive();
        cycle(1'b1, g);
        chk("drop_enable", 32'(bus.rf_write_enable), 32'd0);
        cycle(1'b0, g);
        chk("drop_rf_mem1", 32'(rf_mem[1]), 32'(d_prior));
        v = 3'b111;
        for (int i = 0; i < 3; i++) new_req(i);
        drive();
        cycle(1'b0, g);
        reset = 1'b1;
        cycle(1'b0, g);
        v = 3'b000;
        drive();
        cycle(1'b0, g);

        // Idle: no writes, output address/data hold the last granted write.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, g);
            chk("idle_enable", 32'(bus.rf_write_enable), 32'd0);
            chk("idle_addr", 32'(bus.rf_write_addr), 32'(last_a));
            chk("idle_data", 32'(bus.rf_write_data), 32'(last_d));
        end

        // Random traffic obeying the hold-until-ready rule.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) new_req(i);
            end
            lk = ($urandom_range(0, 7) == 0);
            drive();
            cycle(1'b0, g);
            if (g >= 0) v[g] = 1'b0;
        end
        v = 3'b000;
        lk = 1'b0;
        drive();
        repeat (3) cycle(1'b0, g);

        chk("pending_writes", 32'(q.size()), 32'd0);
        for (int i = 0; i < 4; i++) chk("rf_mem_final", 32'(rf_mem[i]), 32'(model_mem[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
